// File: rtl/comb_sweep_ctrl.sv
// Walks {A,B,C} through all 8 vectors, samples F after a settle time and scores it against a latched truth table.
// Optional SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module comb_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] expected,
  output logic       A,
  output logic       B,
  output logic       C,
  input  logic       F,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] result,
  output logic [3:0] fail_count,
  output logic [2:0] first_fail,
  output logic       first_fail_valid
);

  // state  | meaning
  // IDLE   | waiting for a registered start request
  // SETTLE | holding the current vector on {A,B,C} while F settles
  // SAMPLE | capturing F for the current vector and scoring it
  // DONE   | one-cycle completion pulse, results frozen
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q;
  logic             start_q;
  logic [7:0]       exp_q;
  logic [2:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [7:0]       result_q;
  logic [3:0]       fail_count_q;
  logic [2:0]       first_fail_q;
  logic             first_fail_valid_q;

  logic             mismatch_d;
  logic [3:0]       fail_count_d;
  logic [7:0]       result_d;
  logic             last_d;

  always_comb begin
    mismatch_d   = (F != exp_q[idx_q]);
    fail_count_d = fail_count_q + {3'b000, mismatch_d};
    result_d     = result_q;
    result_d[idx_q] = F;
`ifdef SWEEP_STOP_ON_FAIL_EN
    last_d = (idx_q == 3'd7) || mismatch_d;
`else
    last_d = (idx_q == 3'd7);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      start_q            <= 1'b0;
      exp_q              <= '0;
      idx_q              <= '0;
      cnt_q              <= '0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
      pass_q             <= 1'b0;
      result_q           <= '0;
      fail_count_q       <= '0;
      first_fail_q       <= '0;
      first_fail_valid_q <= 1'b0;
    end else begin
      // A request seen during DONE must not leak into the following IDLE cycle.
      start_q <= start && (state_q != DONE);
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) exp_q <= expected;
          if (start_q) begin
            state_q            <= SETTLE;
            idx_q              <= '0;
            cnt_q              <= CNT_LOAD;
            busy_q             <= 1'b1;
            pass_q             <= 1'b0;
            result_q           <= '0;
            fail_count_q       <= '0;
            first_fail_q       <= '0;
            first_fail_valid_q <= 1'b0;
          end
        end
        SETTLE: begin
          if (cnt_q == '0) state_q <= SAMPLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        SAMPLE: begin
          result_q     <= result_d;
          fail_count_q <= fail_count_d;
          if (mismatch_d && !first_fail_valid_q) begin
            first_fail_q       <= idx_q;
            first_fail_valid_q <= 1'b1;
          end
          if (last_d) begin
            state_q <= DONE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (fail_count_d == 4'd0);
          end else begin
            state_q <= SETTLE;
            idx_q   <= idx_q + 3'd1;
            cnt_q   <= CNT_LOAD;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign A                = idx_q[2];
  assign B                = idx_q[1];
  assign C                = idx_q[0];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign result           = result_q;
  assign fail_count       = fail_count_q;
  assign first_fail       = first_fail_q;
  assign first_fail_valid = first_fail_valid_q;

endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Self-checking bench for comb_sweep_ctrl: datapath modelled as an 8-entry lookup table on {A,B,C}.
module tb_comb_sweep_ctrl;
  localparam int S    = 2;
  localparam int NLOG = 32;
`ifdef SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] expected;
  logic       A, B, C, F;
  logic       busy, done, pass, first_fail_valid;
  logic [7:0] result;
  logic [3:0] fail_count;
  logic [2:0] first_fail;
  logic [7:0] f_tab;

  int tests  = 0;
  int failed = 0;

  logic [2:0] abc_log [NLOG];
  logic       busy_log[NLOG];
  logic       done_log[NLOG];
  int         done_edge, done_cnt;

  always #5 clk = ~clk;
  assign F = f_tab[{A, B, C}];

  comb_sweep_ctrl #(.SETTLE_CYCLES(S), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .expected(expected),
    .A(A), .B(B), .C(C), .F(F),
    .busy(busy), .done(done), .pass(pass), .result(result),
    .fail_count(fail_count), .first_fail(first_fail),
    .first_fail_valid(first_fail_valid)
  );

  // Reference: what a sweep over truth table ft must report against expectation e.
  task automatic model(input logic [7:0] e, input logic [7:0] ft,
                       output logic [7:0] res, output int fc, output int ff,
                       output bit ffv, output bit ps, output int de);
    int n;
    res = 8'h00; fc = 0; ff = 0; ffv = 1'b0; n = 8;
    for (int i = 0; i < 8; i++) begin
      res[i] = ft[i];
      if (ft[i] != e[i]) begin
        fc++;
        if (!ffv) begin ffv = 1'b1; ff = i; end
        if (STOP) begin n = i + 1; break; end
      end
    end
    ps = (fc == 0);
    de = 1 + n * (S + 1);
  endtask

  // Drives one start (edge 0) and logs outputs after each edge; rp1/rp2 re-pulse start.
  task automatic run_sweep(input logic [7:0] e, input logic [7:0] ft, input int rp1, input int rp2);
    @(negedge clk);
    expected = e; f_tab = ft; start = 1'b1;
    @(posedge clk);
    done_edge = -1; done_cnt = 0;
    for (int n = 0; n < NLOG; n++) begin
      @(negedge clk);
      abc_log[n]  = {A, B, C};
      busy_log[n] = busy;
      done_log[n] = done;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_edge < 0) done_edge = n;
      end
      start = ((n + 1) == rp1) || ((n + 1) == rp2);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; expected = 8'hA5; f_tab = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({A, B, C, busy, done, pass, result, fail_count, first_fail, first_fail_valid} !== 22'd0) begin
      failed++;
      $display("FAIL reset_outputs: got busy=%b done=%b result=%h fc=%0d", busy, done, result, fail_count);
    end
    rst = 1'b0; start = 1'b0;
    repeat (4) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin failed++; $display("FAIL reset_start_ignored: busy=%b want 0", busy); end
  endtask

  task automatic test_all_pass();
    logic [7:0] res; int fc, ff, de; bit ffv, ps; int bad;
    model(8'hFF, 8'hFF, res, fc, ff, ffv, ps, de);
    run_sweep(8'hFF, 8'hFF, -1, -1);
    tests++;
    if (busy_log[0] !== 1'b0 || busy_log[1] !== 1'b1) begin
      failed++; $display("FAIL busy_rise: edge0=%b edge1=%b want 0 1", busy_log[0], busy_log[1]);
    end
    tests++;
    if (done_edge != de || done_cnt != 1) begin
      failed++; $display("FAIL allpass_done: edge=%0d cnt=%0d want %0d 1", done_edge, done_cnt, de);
    end
    bad = 0;
    for (int n = 1; n < de; n++) if (abc_log[n] !== 3'((n - 1) / (S + 1)) || busy_log[n] !== 1'b1) bad++;
    tests++;
    if (bad != 0 || abc_log[de] !== 3'd0 || busy_log[de] !== 1'b0) begin
      failed++; $display("FAIL abc_trace: %0d bad cycles, abc@done=%0d busy@done=%b want 0 0 0", bad, abc_log[de], busy_log[de]);
    end
    tests++;
    if (result !== res || fail_count !== 4'(fc) || pass !== ps || first_fail_valid !== ffv) begin
      failed++; $display("FAIL allpass_results: res=%h fc=%0d pass=%b ffv=%b want %h %0d %b %b", result, fail_count, pass, first_fail_valid, res, fc, ps, ffv);
    end
  endtask

  task automatic test_nand3();
    logic [7:0] res; int fc, ff, de; bit ffv, ps;
    model(8'h7F, 8'h7F, res, fc, ff, ffv, ps, de);
    run_sweep(8'h7F, 8'h7F, -1, -1);
    tests++;
    if (done_edge != de || result !== res || pass !== ps || fail_count !== 4'(fc)) begin
      failed++; $display("FAIL nand3: edge=%0d res=%h pass=%b fc=%0d want %0d %h %b %0d", done_edge, result, pass, fail_count, de, res, ps, fc);
    end
  endtask

  task automatic test_mismatch();
    logic [7:0] e; logic [7:0] res; int fc, ff, de; bit ffv, ps;
    for (int k = 0; k < 2; k++) begin
      e = (k == 0) ? 8'h7F : 8'hFE;
      model(e, 8'hFF, res, fc, ff, ffv, ps, de);
      run_sweep(e, 8'hFF, -1, -1);
      tests++;
      if (done_edge != de || result !== res || fail_count !== 4'(fc)) begin
        failed++; $display("FAIL mismatch_%0d_timing: edge=%0d res=%h fc=%0d want %0d %h %0d", k, done_edge, result, fail_count, de, res, fc);
      end
      tests++;
      if (first_fail !== 3'(ff) || first_fail_valid !== ffv || pass !== ps) begin
        failed++; $display("FAIL mismatch_%0d_flags: ff=%0d ffv=%b pass=%b want %0d %b %b", k, first_fail, first_fail_valid, pass, ff, ffv, ps);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] e, ft, res; int fc, ff, de; bit ffv, ps;
    for (int k = 0; k < 12; k++) begin
      e  = 8'($urandom);
      ft = (k % 3 == 0) ? e ^ (8'h01 << $urandom_range(7, 0)) : 8'($urandom);
      model(e, ft, res, fc, ff, ffv, ps, de);
      run_sweep(e, ft, -1, -1);
      tests++;
      if (done_edge != de || done_cnt != 1 || result !== res || fail_count !== 4'(fc)) begin
        failed++; $display("FAIL random_%0d: e=%h ft=%h edge=%0d cnt=%0d res=%h fc=%0d want %0d 1 %h %0d", k, e, ft, done_edge, done_cnt, result, fail_count, de, res, fc);
      end
      tests++;
      if (pass !== ps || first_fail_valid !== ffv || first_fail !== 3'(ff)) begin
        failed++; $display("FAIL random_flags_%0d: pass=%b ffv=%b ff=%0d want %b %b %0d", k, pass, first_fail_valid, first_fail, ps, ffv, ff);
      end
    end
  endtask

  task automatic test_restart_ignored();
    logic [7:0] res; int fc, ff, de; bit ffv, ps;
    model(8'h5A, 8'h3C, res, fc, ff, ffv, ps, de);
    run_sweep(8'h5A, 8'h3C, 5, 12);
    tests++;
    if (done_edge != de || done_cnt != 1 || result !== res || fail_count !== 4'(fc) || first_fail !== 3'(ff)) begin
      failed++; $display("FAIL restart_ignored: edge=%0d cnt=%0d res=%h fc=%0d ff=%0d want %0d 1 %h %0d %0d", done_edge, done_cnt, result, fail_count, first_fail, de, res, fc, ff);
    end
    // A start raised in the DONE cycle must not launch another sweep.
    run_sweep(8'hFF, 8'hFF, 1 + 8 * (S + 1) + 1, -1);
    tests++;
    if (busy_log[NLOG-1] !== 1'b0 || done_cnt != 1) begin
      failed++; $display("FAIL start_in_done: busy=%b dones=%0d want 0 1", busy_log[NLOG-1], done_cnt);
    end
  endtask

  task automatic test_rst_mid();
    int dn; logic [7:0] res; int fc, ff, de; bit ffv, ps;
    dn = 0;
    @(negedge clk);
    expected = 8'hFF; f_tab = 8'hFF; start = 1'b1;
    @(posedge clk);
    for (int n = 0; n < NLOG; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) dn++;
      if (n == 10) begin
        tests++;
        if ({A, B, C} !== 3'd3) begin failed++; $display("FAIL rst_mid_idx: abc=%0d want 3", {A, B, C}); end
        rst = 1'b1;
      end
      if (n == 11) begin
        rst = 1'b0;
        tests++;
        if ({A, B, C, busy, done, pass, result, fail_count, first_fail, first_fail_valid} !== 22'd0) begin
          failed++; $display("FAIL rst_mid_outputs: abc=%0d busy=%b result=%h want 0 0 0", {A, B, C}, busy, result);
        end
      end
    end
    tests++;
    if (dn != 0) begin failed++; $display("FAIL rst_mid_no_done: dones=%0d want 0", dn); end
    model(8'hFF, 8'hFF, res, fc, ff, ffv, ps, de);
    run_sweep(8'hFF, 8'hFF, -1, -1);
    tests++;
    if (done_edge != de || pass !== ps || result !== res) begin
      failed++; $display("FAIL rst_mid_recover: edge=%0d pass=%b res=%h want %0d %b %h", done_edge, pass, result, de, ps, res);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; expected = 8'h00; f_tab = 8'h00;
    test_reset();
    test_all_pass();
    test_nand3();
    test_mismatch();
    test_random();
    test_restart_ignored();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/comb_sweep_ctrl.md
Name: comb_sweep_ctrl

Overview:
- Sequencer that exercises a 3-input/1-output combinational block (A, B, C -> F) in-circuit.
- On a start pulse it drives all 8 input vectors in order, waits a settle time per vector, samples F and compares it against an 8-bit expected truth table.
- Reports captured table, pass flag, mismatch count and first failing vector.
- Sits between a test/config master and the combinational datapath; the datapath's inputs are owned exclusively by this block.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before F is sampled; legal range 1..15.
- CNT_W, 4, width of the settle counter; must hold SETTLE_CYCLES.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request a sweep; accepted only in IDLE
- expected  in  8  bit i = expected F for {A,B,C}=i (A is MSB); latched at start
- A  out  1  datapath input, MSB of vector index
- B  out  1  datapath input
- C  out  1  datapath input, LSB of vector index
- F  in  1  datapath output, sampled in SAMPLE
- busy  out  1  high from the cycle after start acceptance until DONE
- done  out  1  one-cycle pulse at sweep end
- pass  out  1  fail_count==0; valid from done, held until next start
- result  out  8  captured F per vector index
- fail_count  out  4  number of mismatching vectors, 0..8
- first_fail  out  3  lowest mismatching index
- first_fail_valid  out  1  first_fail is meaningful

Behaviour:
- Reset: state IDLE; A, B, C, busy, done, pass, result, fail_count, first_fail, first_fail_valid all 0; latched expected cleared.
- All outputs are registered; no combinational path from F or start to any output.
- States are IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 latches expected, sets idx=0 and {A,B,C}=000.
  - Clears result, fail_count, pass, first_fail and first_fail_valid; loads the settle counter; sets busy=1; moves to SETTLE.
- SETTLE: holds {A,B,C}=idx for SETTLE_CYCLES cycles (counter down to 0), then moves to SAMPLE.
- SAMPLE: one cycle, {A,B,C} still idx. At the edge ending it:
  - result[idx] <= F.
  - On mismatch (F != expected[idx]): fail_count increments. If first_fail_valid=0, first_fail <= idx and first_fail_valid <= 1.
  - If idx==7: go to DONE. Otherwise idx+1 is driven onto {A,B,C} and the block returns to SETTLE.
- Per-vector time is SETTLE_CYCLES+1 cycles. Start is sampled at edge 0, busy rises at edge 1, done is high in the cycle starting at edge 1+8*(SETTLE_CYCLES+1). With the default that is edge 25.
- DONE: one cycle.
  - done=1, busy=0, pass=(fail_count==0), {A,B,C}=000; returns to IDLE.
  - result, pass, fail_count and first_fail hold until the next accepted start.
- Index width is 3 bits; no wrap past 7. fail_count saturates naturally at 8 (4 bits).
- start while busy or in DONE is ignored: no restart, no extension, no effect on results.
- rst mid-sweep: next edge forces the full reset state. No done pulse; partial results are discarded.
- rst and start asserted together: rst wins.

Optional Feature:
- Macro SWEEP_STOP_ON_FAIL_EN.
- Defined: the first mismatch in SAMPLE goes straight to DONE instead of continuing. fail_count=1, pass=0; result holds only vectors 0..first_fail, upper bits stay 0.
- Undefined: all 8 vectors are always applied; the block behaves exactly as described above.

Test Plan:
- expected=8'hFF, F tied 1, SETTLE_CYCLES=2, start pulse -> busy at edge 1, done at edge 25, pass=1, result=8'hFF, fail_count=0, first_fail_valid=0; A,B,C step 000..111, each held 3 cycles.
- F from NAND3(A,B,C) model, expected=8'h7F -> done, pass=1, result=8'h7F.
- F tied 1, expected=8'h7F -> result=8'hFF, fail_count=1, first_fail=7, first_fail_valid=1, pass=0.
- Sweep with F tied 1: assert rst for 1 cycle while idx=3 -> next cycle all outputs 0, state IDLE, no done. A fresh start then completes normally with done at edge 25 after it.
- start re-pulsed at edges 5 and 12 during a sweep -> done still at edge 25, exactly one done pulse, results unchanged vs. the single-start run.
- expected=8'hFE, F tied 1:
  - With SWEEP_STOP_ON_FAIL_EN: done at edge 4, fail_count=1, first_fail=0, result=8'h01.
  - Without the macro: done at edge 25, fail_count=1, result=8'hFF.
